// File: rtl/exc_ctrl_pkg.sv
// Shared exception codes, MEM exception flag positions, CP0 addresses and FSM encoding.
package exc_ctrl_pkg;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

    localparam logic [4:0] EXC_INT  = 5'h01;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;
    localparam logic [4:0] EXC_TR   = 5'h0d;
    localparam logic [4:0] EXC_ERET = 5'h0e;

    localparam int EB_FETCH_ADEL = 0;
    localparam int EB_RI         = 1;
    localparam int EB_OV         = 2;
    localparam int EB_TRAP       = 3;
    localparam int EB_SYSCALL    = 4;
    localparam int EB_LOAD_ADEL  = 5;
    localparam int EB_ADES       = 6;
    localparam int EB_ERET       = 7;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_BUS = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_DRAIN    = 2'd3
    } state_e;

    typedef struct packed {
        logic [4:0]  code;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] badv;
        logic [31:0] npc;
    } exc_rec_t;

    function automatic logic [4:0] exc_code(input logic irq, input logic [7:0] exc);
        logic [4:0] code;
        code = 5'h00;
        if (irq)                     code = EXC_INT;
        else if (exc[EB_FETCH_ADEL]) code = EXC_ADEL;
        else if (exc[EB_RI])         code = EXC_RI;
        else if (exc[EB_OV])         code = EXC_OV;
        else if (exc[EB_TRAP])       code = EXC_TR;
        else if (exc[EB_SYSCALL])    code = EXC_SYS;
        else if (exc[EB_LOAD_ADEL])  code = EXC_ADEL;
        else if (exc[EB_ADES])       code = EXC_ADES;
        else if (exc[EB_ERET])       code = EXC_ERET;
        return code;
    endfunction

    // Only address errors report a bad address; the winning cause decides which one.
    function automatic logic [31:0] exc_badv(input logic irq, input logic [7:0] exc,
                                             input logic [31:0] pc, input logic [31:0] badv);
        logic [31:0] res;
        res = 32'h0;
        if (!irq) begin
            if (exc[EB_FETCH_ADEL])
                res = pc;
            else if (exc[EB_SYSCALL:EB_RI] == 4'b0 && (exc[EB_LOAD_ADEL] || exc[EB_ADES]))
                res = badv;
        end
        return res;
    endfunction

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Multi-flop synchronizer for the external interrupt lines.
// Latency: STAGES clocks. No backpressure.
// Flops clear on async reset.
module int_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;
    logic [STAGES-1:0][WIDTH-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) chain_q <= '0;
        else      chain_q <= chain_d;
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: prioritizes MEM exceptions vs interrupts, issues one commit to CP0.
// Latency: request N -> flush N+1 (bus idle) or the cycle after bus_busy_i falls.
// Backpressure: stall_o held while waiting on the bus and for one drain cycle after commit.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  hw_int_i,
    input  logic        timer_int_i,
    output logic [5:0]  int_sync_o,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] mem_badvaddr_i,
    input  logic [7:0]  mem_exc_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        cp0_wen_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [31:0] cp0_wdata_i,
    input  logic        bus_busy_i,
    output logic        stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [31:0] exc_type_o,
    output logic [31:0] exc_pc_o,
    output logic        exc_delayslot_o,
    output logic [31:0] exc_badvaddr_o
);

    logic [5:0]  hw_sync;
    logic [31:0] status_byp;
    logic [31:0] epc_byp;
    logic [1:0]  sw_ip;
    logic [7:0]  ip;
    logic        irq_pend;
    logic        req;
    logic        commit;
    exc_rec_t    req_rec;
    exc_rec_t    rec_q, rec_d;
    state_e      state_q, state_d;
    logic        unused_bits;

    int_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (6)
    ) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d_i (hw_int_i),
        .q_o (hw_sync)
    );

    // Timer is already synchronous, so it joins IP7 after the synchronizer.
    assign int_sync_o = {hw_sync[5] | timer_int_i, hw_sync[4:0]};

    always_comb begin
        status_byp = (cp0_wen_i && cp0_waddr_i == CP0_STATUS) ? cp0_wdata_i : cp0_status_i;
        sw_ip      = (cp0_wen_i && cp0_waddr_i == CP0_CAUSE) ? cp0_wdata_i[9:8] : cp0_cause_i[9:8];
        epc_byp    = (cp0_wen_i && cp0_waddr_i == CP0_EPC) ? cp0_wdata_i : cp0_epc_i;
        ip         = {int_sync_o, sw_ip};
        irq_pend   = status_byp[0] & ~status_byp[1] & (|(ip & status_byp[15:8]));
        req        = mem_valid_i & (irq_pend | (|mem_exc_i));
    end

    always_comb begin
        req_rec.code = exc_code(irq_pend, mem_exc_i);
        req_rec.pc   = mem_pc_i;
        req_rec.ds   = mem_in_delayslot_i;
        req_rec.badv = exc_badv(irq_pend, mem_exc_i, mem_pc_i, mem_badvaddr_i);
        req_rec.npc  = (req_rec.code == EXC_ERET) ? epc_byp : EXC_VECTOR;
    end

    always_comb begin
        state_d = state_q;
        rec_d   = rec_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    rec_d   = req_rec;
                    state_d = bus_busy_i ? ST_WAIT_BUS : ST_COMMIT;
                end
            end
            ST_WAIT_BUS: if (!bus_busy_i) state_d = ST_COMMIT;
            ST_COMMIT:   state_d = ST_DRAIN;
            ST_DRAIN:    state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rec_q   <= '0;
        end else begin
            state_q <= state_d;
            rec_q   <= rec_d;
        end
    end

    // Outputs decode from flops only; everything outside COMMIT reads as zero.
    assign commit          = (state_q == ST_COMMIT);
    assign stall_o         = (state_q == ST_WAIT_BUS) || (state_q == ST_DRAIN);
    assign flush_o         = commit;
    assign new_pc_o        = commit ? rec_q.npc : 32'h0;
    assign exc_type_o      = commit ? {27'h0, rec_q.code} : 32'h0;
    assign exc_pc_o        = commit ? rec_q.pc : 32'h0;
    assign exc_delayslot_o = commit & rec_q.ds;
    assign exc_badvaddr_o  = commit ? rec_q.badv : 32'h0;

    assign unused_bits = ^{status_byp[31:16], status_byp[7:2], cp0_cause_i[31:10], cp0_cause_i[7:0]};

endmodule

// File: tb/tb_exc_ctrl.sv
// Table-driven bench for exc_ctrl with a commit scoreboard plus hand-written corner sequences.
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  hw_int;
    logic        timer_int;
    logic [5:0]  int_sync;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_ds;
    logic [31:0] mem_badv;
    logic [7:0]  mem_exc;
    logic [31:0] status, cause, epc;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        bus_busy;
    logic        stall, flush;
    logic [31:0] new_pc, exc_type, exc_pc, exc_badv;
    logic        exc_ds;

    always #5 clk = ~clk;

    exc_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .hw_int_i           (hw_int),
        .timer_int_i        (timer_int),
        .int_sync_o         (int_sync),
        .mem_valid_i        (mem_valid),
        .mem_pc_i           (mem_pc),
        .mem_in_delayslot_i (mem_ds),
        .mem_badvaddr_i     (mem_badv),
        .mem_exc_i          (mem_exc),
        .cp0_status_i       (status),
        .cp0_cause_i        (cause),
        .cp0_epc_i          (epc),
        .cp0_wen_i          (wen),
        .cp0_waddr_i        (waddr),
        .cp0_wdata_i        (wdata),
        .bus_busy_i         (bus_busy),
        .stall_o            (stall),
        .flush_o            (flush),
        .new_pc_o           (new_pc),
        .exc_type_o         (exc_type),
        .exc_pc_o           (exc_pc),
        .exc_delayslot_o    (exc_ds),
        .exc_badvaddr_o     (exc_badv)
    );

    typedef struct {
        logic        vld;
        logic [7:0]  exc;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] badv;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        int          busy;
        logic        late_int;
        logic        commit;
        logic [4:0]  e_type;
        logic [31:0] e_npc;
        logic [31:0] e_badv;
    } vec_t;

    typedef struct {
        logic [31:0] typ;
        logic [31:0] npc;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] badv;
        int          req_cyc;
        int          lat;
    } exp_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic vec_t mk(input logic vld, input logic [7:0] exc, input logic [31:0] pc,
                                input logic ds, input logic [31:0] badv, input logic [31:0] st,
                                input logic [31:0] ca, input logic [31:0] ep, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd, input int busy,
                                input logic late, input logic commit, input logic [4:0] et,
                                input logic [31:0] enpc, input logic [31:0] ebadv);
        vec_t v;
        v.vld = vld; v.exc = exc; v.pc = pc; v.ds = ds; v.badv = badv;
        v.status = st; v.cause = ca; v.epc = ep; v.wen = we; v.waddr = wa; v.wdata = wd;
        v.busy = busy; v.late_int = late; v.commit = commit;
        v.e_type = et; v.e_npc = enpc; v.e_badv = ebadv;
        return v;
    endfunction

    // Scoreboard: every flush must match the oldest pending expectation.
    always @(negedge clk) begin
        if (flush) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL stray_flush: flush_o=1 with pc %h, expected no commit", exc_pc);
            end else begin
                mon_e = sb.pop_front();
                check("exc_type", exc_type, mon_e.typ);
                check("new_pc", new_pc, mon_e.npc);
                check("exc_pc", exc_pc, mon_e.pc);
                check("exc_ds", {31'h0, exc_ds}, {31'h0, mon_e.ds});
                check("exc_badv", exc_badv, mon_e.badv);
                check("latency", cyc - mon_e.req_cyc, mon_e.lat);
            end
        end
    end

    task automatic apply(input vec_t v);
        exp_t e;
        @(posedge clk); #1;
        mem_valid = v.vld; mem_exc = v.exc; mem_pc = v.pc; mem_ds = v.ds; mem_badv = v.badv;
        status = v.status; cause = v.cause; epc = v.epc;
        wen = v.wen; waddr = v.waddr; wdata = v.wdata;
        bus_busy = (v.busy > 0);
        if (v.commit) begin
            e.typ = {27'h0, v.e_type}; e.npc = v.e_npc; e.pc = v.pc; e.ds = v.ds;
            e.badv = v.e_badv; e.req_cyc = cyc; e.lat = 1 + v.busy;
            sb.push_back(e);
        end
        for (int k = 1; k <= v.busy + 3; k++) begin
            @(posedge clk); #1;
            mem_valid = 1'b0; mem_exc = 8'h0; wen = 1'b0;
            bus_busy = (k < v.busy);
            if (v.late_int && k == 1) begin
                status = 32'h0000FF01;
                cause  = 32'h00000100;
            end
            @(negedge clk);
            if (!v.commit) begin
                check("no_flush", {31'h0, flush}, 32'h0);
                check("no_stall", {31'h0, stall}, 32'h0);
            end else if (k <= v.busy) check("wait_stall", {31'h0, stall}, 32'h1);
            else if (k == v.busy + 1) check("commit_stall", {31'h0, stall}, 32'h0);
            else if (k == v.busy + 2) check("drain_stall", {31'h0, stall}, 32'h1);
            else check("idle_stall", {31'h0, stall}, 32'h0);
        end
        check("sb_empty", sb.size(), 32'h0);
        status = 32'h0; cause = 32'h0; epc = 32'h0; mem_pc = 32'h0; mem_badv = 32'h0; mem_ds = 1'b0;
    endtask

    task automatic check_outputs_zero();
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_flush", {31'h0, flush}, 32'h0);
        check("rst_new_pc", new_pc, 32'h0);
        check("rst_exc_type", exc_type, 32'h0);
        check("rst_exc_pc", exc_pc, 32'h0);
        check("rst_exc_ds", {31'h0, exc_ds}, 32'h0);
        check("rst_exc_badv", exc_badv, 32'h0);
        check("rst_int_sync", {26'h0, int_sync}, 32'h0);
    endtask

    initial begin
        rst = 1'b0; hw_int = 6'h3F; timer_int = 1'b0;
        mem_valid = 1'b0; mem_pc = 32'h0; mem_ds = 1'b0; mem_badv = 32'h0; mem_exc = 8'h0;
        status = 32'h0; cause = 32'h0; epc = 32'h0;
        wen = 1'b0; waddr = 5'h0; wdata = 32'h0; bus_busy = 1'b0;

        //   vld exc    pc            ds badv          status        cause   epc     wen wa  wdata         busy late cmt type   npc           badv
        vecs.push_back(mk(1, 8'h10, 32'hBFC00100, 0, 32'h00001234, 32'h0,        32'h0,   32'h0,    0, 0,  32'h0,        0, 0, 1, 5'h08, VEC,          32'h0));
        vecs.push_back(mk(1, 8'h40, 32'hBFC00200, 1, 32'h80000003, 32'h0,        32'h0,   32'h0,    0, 0,  32'h0,        3, 0, 1, 5'h05, VEC,          32'h80000003));
        vecs.push_back(mk(1, 8'h80, 32'hBFC00300, 0, 32'h0,        32'h0,        32'h0,   32'h1000, 1, 14, 32'h2000,     0, 0, 1, 5'h0e, 32'h2000,     32'h0));
        vecs.push_back(mk(1, 8'h80, 32'hBFC00304, 0, 32'h0,        32'h0,        32'h0,   32'h1000, 1, 13, 32'h2000,     0, 0, 1, 5'h0e, 32'h1000,     32'h0));
        vecs.push_back(mk(1, 8'h03, 32'hBFC00404, 0, 32'h00000055, 32'h0,        32'h0,   32'h0,    0, 0,  32'h0,        0, 0, 1, 5'h04, VEC,          32'hBFC00404));
        vecs.push_back(mk(1, 8'h0A, 32'hBFC00408, 0, 32'h00000055, 32'h0,        32'h0,   32'h0,    0, 0,  32'h0,        0, 0, 1, 5'h0a, VEC,          32'h0));
        vecs.push_back(mk(1, 8'h0C, 32'hBFC0040C, 0, 32'h0,        32'h0,        32'h0,   32'h0,    0, 0,  32'h0,        0, 0, 1, 5'h0c, VEC,          32'h0));
        vecs.push_back(mk(1, 8'h18, 32'hBFC00410, 0, 32'h0,        32'h0,        32'h0,   32'h0,    0, 0,  32'h0,        0, 0, 1, 5'h0d, VEC,          32'h0));
        vecs.push_back(mk(1, 8'h30, 32'hBFC00414, 0, 32'h0000AAAA, 32'h0,        32'h0,   32'h0,    0, 0,  32'h0,        0, 0, 1, 5'h08, VEC,          32'h0));
        vecs.push_back(mk(1, 8'h60, 32'hBFC00418, 0, 32'h80000011, 32'h0,        32'h0,   32'h0,    0, 0,  32'h0,        0, 0, 1, 5'h04, VEC,          32'h80000011));
        vecs.push_back(mk(1, 8'h00, 32'hBFC00500, 1, 32'h00000077, 32'h0000FF01, 32'h100, 32'h0,    0, 0,  32'h0,        0, 0, 1, 5'h01, VEC,          32'h0));
        vecs.push_back(mk(1, 8'h80, 32'hBFC00504, 0, 32'h0,        32'h0000FF01, 32'h200, 32'h1000, 0, 0,  32'h0,        0, 0, 1, 5'h01, VEC,          32'h0));
        vecs.push_back(mk(1, 8'h00, 32'hBFC00508, 0, 32'h0,        32'h0,        32'h100, 32'h0,    1, 12, 32'h0000FF01, 0, 0, 1, 5'h01, VEC,          32'h0));
        vecs.push_back(mk(1, 8'h00, 32'hBFC0050C, 0, 32'h0,        32'h0000FF01, 32'h0,   32'h0,    1, 13, 32'h00000300, 0, 0, 1, 5'h01, VEC,          32'h0));
        vecs.push_back(mk(1, 8'h00, 32'hBFC00510, 0, 32'h0,        32'h0000FF03, 32'h100, 32'h0,    0, 0,  32'h0,        0, 0, 0, 5'h00, 32'h0,        32'h0));
        vecs.push_back(mk(1, 8'h00, 32'hBFC00514, 0, 32'h0,        32'h00000101, 32'h200, 32'h0,    0, 0,  32'h0,        0, 0, 0, 5'h00, 32'h0,        32'h0));
        vecs.push_back(mk(1, 8'h04, 32'hBFC00518, 0, 32'h0,        32'h0000FF00, 32'h100, 32'h0,    0, 0,  32'h0,        0, 0, 1, 5'h0c, VEC,          32'h0));
        vecs.push_back(mk(1, 8'h00, 32'hBFC0051C, 0, 32'h0,        32'h0000FF01, 32'h0,   32'h0,    1, 13, 32'h0000FC00, 0, 0, 0, 5'h00, 32'h0,        32'h0));
        vecs.push_back(mk(0, 8'h10, 32'hBFC00520, 0, 32'h0,        32'h0,        32'h0,   32'h0,    0, 0,  32'h0,        0, 0, 0, 5'h00, 32'h0,        32'h0));
        vecs.push_back(mk(1, 8'h10, 32'hBFC00524, 0, 32'h0,        32'h0,        32'h0,   32'h0,    0, 0,  32'h0,        2, 1, 1, 5'h08, VEC,          32'h0));
        vecs.push_back(mk(1, 8'h20, 32'hBFC00528, 1, 32'h00004001, 32'h0,        32'h0,   32'h0,    0, 0,  32'h0,        1, 0, 1, 5'h04, VEC,          32'h00004001));
        vecs.push_back(mk(1, 8'h00, 32'hBFC0052C, 0, 32'h0,        32'h0000FF01, 32'h100, 32'h0,    1, 12, 32'h0,        0, 0, 0, 5'h00, 32'h0,        32'h0));

        #12;
        check_outputs_zero();
        hw_int = 6'h0;
        @(negedge clk); rst = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // External interrupt through the synchronizer, then masked by EXL.
        @(posedge clk); #1; hw_int = 6'h04;
        @(negedge clk); check("sync_0clk", {26'h0, int_sync}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk); check("sync_1clk", {26'h0, int_sync}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk); check("sync_2clk", {26'h0, int_sync}, 32'h04);
        apply(mk(1, 8'h00, 32'hBFC00600, 0, 32'h0, 32'h0000FF01, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 1, 5'h01, VEC, 32'h0));
        apply(mk(1, 8'h00, 32'hBFC00604, 0, 32'h0, 32'h0000FF03, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 5'h00, 32'h0, 32'h0));
        @(posedge clk); #1; timer_int = 1'b1;
        @(negedge clk); check("timer_or", {26'h0, int_sync}, 32'h24);
        @(posedge clk); #1; timer_int = 1'b0; hw_int = 6'h0;
        repeat (3) @(posedge clk);

        // Reset while waiting on the bus: no partial commit afterwards.
        #1; mem_valid = 1'b1; mem_exc = 8'h10; mem_pc = 32'hBFC00700; bus_busy = 1'b1;
        @(posedge clk); #1; mem_valid = 1'b0; mem_exc = 8'h0;
        @(negedge clk); check("wait_before_rst", {31'h0, stall}, 32'h1);
        @(posedge clk); #2; rst = 1'b0;
        #1; check_outputs_zero();
        @(negedge clk); rst = 1'b1; bus_busy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post_rst_flush", {31'h0, flush}, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
